rf_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32x32 CPU register file. It shares the register file's single write port between two writeback requesters:
- port 0: main datapath writeback;
- port 1: a multi-cycle unit such as a divider or a load return.

Each requester uses a valid/ready handshake. The block registers the winning write and drives the register file's write-enable, address and data on the following cycle. It also keeps a saturating count of contention cycles for performance analysis.

---
 rtl/rf_wb_arbiter_if.sv | 38 +++
 rtl/rf_wb_arbiter.sv | 108 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// ============================================================================
//  Module      : rf_wb_arbiter_if
//  Description : Writeback request bus carrying two valid/ready requesters
//                (port 0: main datapath, port 1: multi-cycle unit) into the
//                register-file write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rf_wb_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          s0_valid;
   logic          s0_ready;
   logic [AW-1:0] s0_addr;
   logic [DW-1:0] s0_data;
   logic          s1_valid;
   logic          s1_ready;
   logic [AW-1:0] s1_addr;
   logic [DW-1:0] s1_data;

   // Requester side: drives requests, observes grants
   modport master (
      output s0_valid, s0_addr, s0_data,
      output s1_valid, s1_addr, s1_data,
      input  s0_ready, s1_ready
   );

   // Arbiter side: observes requests, drives grants
   modport slave (
      input  s0_valid, s0_addr, s0_data,
      input  s1_valid, s1_addr, s1_data,
      output s0_ready, s1_ready
   );
endinterface

`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Shares the single write port of the 32x32 register file
//                between two writeback requesters. The winning request is
//                registered and presented to the register file one cycle
//                later. A saturating counter tracks contention cycles.
//                Build option: RF_WB_ARB_RR_EN selects round-robin
//                arbitration; when undefined, port 0 has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_arbiter #(
   parameter int DW    = 32,
   parameter int AW    = 5,
   parameter int CNT_W = 16
) (
   input  wire logic             clk,
   input  wire logic             rst,
   rf_wb_arbiter_if.slave        bus,
   output logic                  rf_we,
   output logic [AW-1:0]         rf_wR,
   output logic [DW-1:0]         rf_wD,
   output logic [CNT_W-1:0]      conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic          both_valid;
   logic          gnt0;
   logic          gnt1;
   logic          xfer;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;

   logic             rf_we_q, rf_we_d;
   logic [AW-1:0]    rf_wr_q, rf_wr_d;
   logic [DW-1:0]    rf_wd_q, rf_wd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef RF_WB_ARB_RR_EN
   // last_q = port of the most recent transfer; 1 after reset so port 0
   // wins the first conflict.
   logic last_q, last_d;
`endif

   // Arbitration: pick at most one valid requester this cycle
   always_comb begin
      both_valid = bus.s0_valid & bus.s1_valid;
`ifdef RF_WB_ARB_RR_EN
      gnt0 = bus.s0_valid & (~bus.s1_valid | last_q);
`else
      gnt0 = bus.s0_valid;
`endif
      gnt1 = bus.s1_valid & ~gnt0;
   end

   // Grants are suppressed while reset is held so nothing transfers
   assign bus.s0_ready = gnt0 & ~rst;
   assign bus.s1_ready = gnt1 & ~rst;

   // Next-state for the output stage, counter and priority pointer
   always_comb begin
      xfer     = bus.s0_ready | bus.s1_ready;
      sel_addr = bus.s1_ready ? bus.s1_addr : bus.s0_addr;
      sel_data = bus.s1_ready ? bus.s1_data : bus.s0_data;

      // Writes to register 0 complete the handshake but never commit
      rf_we_d  = xfer && (sel_addr != '0);
      rf_wr_d  = xfer ? sel_addr : rf_wr_q;
      rf_wd_d  = xfer ? sel_data : rf_wd_q;

      cnt_d    = (both_valid && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_ONE) : cnt_q;
`ifdef RF_WB_ARB_RR_EN
      last_d   = xfer ? bus.s1_ready : last_q;
`endif
   end

   // State registers; reset immediately cancels any pending commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q <= 1'b0;
         rf_wr_q <= '0;
         rf_wd_q <= '0;
         cnt_q   <= '0;
`ifdef RF_WB_ARB_RR_EN
         last_q  <= 1'b1;
`endif
      end else begin
         rf_we_q <= rf_we_d;
         rf_wr_q <= rf_wr_d;
         rf_wd_q <= rf_wd_d;
         cnt_q   <= cnt_d;
`ifdef RF_WB_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

   assign rf_we        = rf_we_q;
   assign rf_wR        = rf_wr_q;
   assign rf_wD        = rf_wd_q;
   assign conflict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter. Expected register
//                file writes are queued when a grant is predicted and popped
//                when the write appears on the rf_* outputs. A second
//                instance with CNT_W = 4 exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_arbiter;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic clk;
   logic rst;

   rf_wb_arbiter_if #(.DW(32), .AW(5)) ifc ();
   rf_wb_arbiter_if #(.DW(32), .AW(5)) ifc2 ();

   logic        rf_we;
   logic [4:0]  rf_wR;
   logic [31:0] rf_wD;
   logic [15:0] conflict_cnt;

   logic        rf_we2;
   logic [4:0]  rf_wR2;
   logic [31:0] rf_wD2;
   logic [3:0]  conflict_cnt2;

   rf_wb_arbiter #(.DW(32), .AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(ifc.slave),
      .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD), .conflict_cnt(conflict_cnt)
   );

   rf_wb_arbiter #(.DW(32), .AW(5), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .bus(ifc2.slave),
      .rf_we(rf_we2), .rf_wR(rf_wR2), .rf_wD(rf_wD2), .conflict_cnt(conflict_cnt2)
   );

   assign ifc2.s0_valid = ifc.s0_valid;
   assign ifc2.s0_addr  = ifc.s0_addr;
   assign ifc2.s0_data  = ifc.s0_data;
   assign ifc2.s1_valid = ifc.s1_valid;
   assign ifc2.s1_addr  = ifc.s1_addr;
   assign ifc2.s1_data  = ifc.s1_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int  n_cmp = 0;
   int  n_err = 0;
   wr_t exp_q[$];
   logic m_last;
   int  m_cnt;
   int  m_cnt2;

   // Scoreboard: each predicted commit must appear one cycle after its grant
   always @(negedge clk) begin
      if (!rst) begin
         wr_t e;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rf_we !== 1'b1 || rf_wR !== e.a || rf_wD !== e.d) begin
               n_err++;
               $display("FAIL rf_write: got we=%0b addr=%0d data=%h, want we=1 addr=%0d data=%h",
                        rf_we, rf_wR, rf_wD, e.a, e.d);
            end
         end else begin
            n_cmp++;
            if (rf_we !== 1'b0) begin
               n_err++;
               $display("FAIL rf_idle: got we=%0b, want we=0", rf_we);
            end
         end
         n_cmp++;
         if (conflict_cnt !== 16'(m_cnt) || conflict_cnt2 !== 4'(m_cnt2)) begin
            n_err++;
            $display("FAIL conflict_cnt: got %0d/%0d, want %0d/%0d",
                     conflict_cnt, conflict_cnt2, m_cnt, m_cnt2);
         end
      end
   end

   // Drives one cycle of requests; returns the observed readys and updates
   // the reference model (priority pointer, counters, expected writes).
   task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       output logic r0, output logic r1);
      logic e0, e1;
      ifc.s0_valid = v0; ifc.s0_addr = a0; ifc.s0_data = d0;
      ifc.s1_valid = v1; ifc.s1_addr = a1; ifc.s1_data = d1;
      @(negedge clk);
      r0 = ifc.s0_ready;
      r1 = ifc.s1_ready;
`ifdef RF_WB_ARB_RR_EN
      e0 = v0 && (!v1 || m_last);
`else
      e0 = v0;
`endif
      e1 = v1 && !e0;
      @(posedge clk);
      if (e0 && a0 != 5'd0) exp_q.push_back('{a: a0, d: d0});
      if (e1 && a1 != 5'd0) exp_q.push_back('{a: a1, d: d1});
      if (e0 || e1) m_last = e1;
      if (v0 && v1) begin
         if (m_cnt  < 65535) m_cnt++;
         if (m_cnt2 < 15)    m_cnt2++;
      end
      #1;
   endtask

   task automatic idle_step();
      logic r0, r1;
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r0, r1);
   endtask

   task automatic apply_reset();
      ifc.s0_valid = 1'b0;
      ifc.s1_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      m_last = 1'b1;
      m_cnt  = 0;
      m_cnt2 = 0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      m_last = 1'b1; m_cnt = 0; m_cnt2 = 0;
      ifc.s0_valid = 1'b1; ifc.s0_addr = 5'd3; ifc.s0_data = 32'h1;
      ifc.s1_valid = 1'b1; ifc.s1_addr = 5'd4; ifc.s1_data = 32'h2;
      #2;
      n_cmp++;
      if (rf_we !== 1'b0 || rf_wR !== 5'd0 || rf_wD !== 32'd0 || conflict_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h cnt=%0d, want all 0",
                  rf_we, rf_wR, rf_wD, conflict_cnt);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (ifc.s0_ready !== 1'b0 || ifc.s1_ready !== 1'b0 || rf_we !== 1'b0 || conflict_cnt !== 16'd0) begin
         n_err++;
         $display("FAIL reset_ready: got r0=%0b r1=%0b we=%0b cnt=%0d, want 0 0 0 0",
                  ifc.s0_ready, ifc.s1_ready, rf_we, conflict_cnt);
      end
      apply_reset();
   endtask

   task automatic test_single_write();
      logic r0, r1;
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, r0, r1);
      n_cmp++;
      if (r0 !== 1'b1 || r1 !== 1'b0) begin
         n_err++;
         $display("FAIL single_ready: got r0=%0b r1=%0b, want 1 0", r0, r1);
      end
      n_cmp++;
      if (rf_we !== 1'b1 || rf_wR !== 5'd5 || rf_wD !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL single_commit: got we=%0b addr=%0d data=%h, want 1 5 deadbeef",
                  rf_we, rf_wR, rf_wD);
      end
      idle_step();
   endtask

   task automatic test_reg0_discard();
      logic r0, r1;
      int cnt0;
      cnt0 = m_cnt;
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h12345678, r0, r1);
      n_cmp++;
      if (r0 !== 1'b0 || r1 !== 1'b1) begin
         n_err++;
         $display("FAIL reg0_ready: got r0=%0b r1=%0b, want 0 1", r0, r1);
      end
      n_cmp++;
      if (rf_we !== 1'b0 || conflict_cnt !== 16'(cnt0)) begin
         n_err++;
         $display("FAIL reg0_discard: got we=%0b cnt=%0d, want 0 %0d", rf_we, conflict_cnt, cnt0);
      end
      idle_step();
   endtask

   task automatic test_conflict();
      logic r0, r1, w0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 5'd3, 32'hA0, 1'b1, 5'd4, 32'hB0, r0, r1);
`ifdef RF_WB_ARB_RR_EN
         w0 = (i % 2 == 0);
`else
         w0 = 1'b1;
`endif
         n_cmp++;
         if (r0 !== w0 || r1 !== !w0) begin
            n_err++;
            $display("FAIL conflict_grant[%0d]: got r0=%0b r1=%0b, want %0b %0b", i, r0, r1, w0, !w0);
         end
      end
      n_cmp++;
      if (conflict_cnt !== 16'd6) begin
         n_err++;
         $display("FAIL conflict_count: got %0d, want 6", conflict_cnt);
      end
      idle_step();
   endtask

   task automatic test_same_addr();
      logic r0, r1;
      apply_reset();
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, r0, r1);
      n_cmp++;
      if (r0 !== 1'b1 || r1 !== 1'b0) begin
         n_err++;
         $display("FAIL same_first: got r0=%0b r1=%0b, want 1 0", r0, r1);
      end
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2, r0, r1);
      n_cmp++;
      if (r0 !== 1'b0 || r1 !== 1'b1) begin
         n_err++;
         $display("FAIL same_second: got r0=%0b r1=%0b, want 0 1", r0, r1);
      end
      idle_step();
      n_cmp++;
      if (rf_wR !== 5'd7 || rf_wD !== 32'h2) begin
         n_err++;
         $display("FAIL same_final: got addr=%0d data=%h, want 7 00000002", rf_wR, rf_wD);
      end
   endtask

   task automatic test_back_to_back();
      logic r0, r1;
      for (int i = 1; i <= 4; i++) begin
         step(1'b1, 5'(i + 10), 32'hC000_0000 + 32'(i), 1'b0, 5'd0, 32'd0, r0, r1);
         n_cmp++;
         if (r0 !== 1'b1 || r1 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ready[%0d]: got r0=%0b r1=%0b, want 1 0", i, r0, r1);
         end
      end
      idle_step();
   endtask

   task automatic test_reset_midflight();
      logic r0, r1;
      step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, r0, r1);
      ifc.s0_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (rf_we !== 1'b0 || rf_wD !== 32'd0) begin
         n_err++;
         $display("FAIL midflight_drop: got we=%0b data=%h, want 0 00000000", rf_we, rf_wD);
      end
      exp_q.delete();
      m_last = 1'b1; m_cnt = 0; m_cnt2 = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      step(1'b1, 5'd2, 32'h22, 1'b1, 5'd6, 32'h66, r0, r1);
      n_cmp++;
      if (r0 !== 1'b1 || r1 !== 1'b0) begin
         n_err++;
         $display("FAIL midflight_regrant: got r0=%0b r1=%0b, want 1 0", r0, r1);
      end
      idle_step();
   endtask

   task automatic test_saturation();
      logic r0, r1;
      apply_reset();
      for (int i = 0; i < 20; i++)
         step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, r0, r1);
      n_cmp++;
      if (conflict_cnt2 !== 4'd15 || conflict_cnt !== 16'd20) begin
         n_err++;
         $display("FAIL saturation: got cnt4=%0d cnt16=%0d, want 15 20", conflict_cnt2, conflict_cnt);
      end
      idle_step();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_reg0_discard();
      test_conflict();
      test_same_addr();
      test_back_to_back();
      test_reset_midflight();
      test_saturation();
      idle_step();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d writes outstanding, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
